mem_stage: RTL and testbench

- Memory-access stage of the 5-stage in-order pipeline; sits between EX and WB and produces mem_to_wb_bus for the WB stage.
- Registers the EX→MEM bus and extends and aligns load data returned by the synchronous data SRAM.
- Holds the returned SRAM word across MEM stalls so the load result is never lost.
- Optionally forwards its result to ID for hazard bypass.

---
 rtl/mem_stage_if.sv | 33 +++
 rtl/mem_stage.sv | 108 ++++++++++
 tb/tb_mem_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM/WB pipeline bus bundle for the memory-access stage
//
// Signals:
//   flush           pipeline flush (synchronous)
//   stall           per-stage stall, bit 3 = MEM, bit 4 = WB, 1 = stop
//   ex_to_mem_bus   {pc, mem_ren, load_op, rf_we, rf_waddr, ex_result}
//   data_sram_rdata data SRAM read word, valid one cycle after the EX request
//   mem_to_wb_bus   {pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_id_bus   {rf_we, rf_waddr, rf_wdata} bypass to ID
// Modports: master drives the stage inputs, slave is the mem_stage side.

interface mem_stage_if #(
    parameter int STALL_W     = 6,
    parameter int EX_TO_MEM_W = 74,
    parameter int MEM_TO_WB_W = 70
);
    logic                   flush;
    logic [STALL_W-1:0]     stall;
    logic [EX_TO_MEM_W-1:0] ex_to_mem_bus;
    logic [31:0]            data_sram_rdata;
    logic [MEM_TO_WB_W-1:0] mem_to_wb_bus;
    logic [37:0]            mem_to_id_bus;

    modport master (
        output flush, stall, ex_to_mem_bus, data_sram_rdata,
        input  mem_to_wb_bus, mem_to_id_bus
    );

    modport slave (
        input  flush, stall, ex_to_mem_bus, data_sram_rdata,
        output mem_to_wb_bus, mem_to_id_bus
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage: EX->MEM register, load align/extend, SRAM word hold
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mem_stage_if.slave (flush, stall, ex_to_mem_bus, data_sram_rdata in;
//        mem_to_wb_bus, mem_to_id_bus out)
// Build option:
//   MEM_FWD_EN  when defined, mem_to_id_bus carries the stage result for ID
//               bypass; otherwise it is tied to zero.

module mem_stage (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   bus
);
    logic [73:0] r;
    logic        first;
    logic        hv;
    logic [31:0] rdata_h;

    logic        stall_mem;
    logic        stall_wb;
    logic        unused_stall;

    assign stall_mem    = bus.stall[3];
    assign stall_wb     = bus.stall[4];
    assign unused_stall = ^{bus.stall[5], bus.stall[2:0]};

    // Any path other than a plain hold reloads r. "first" marks the single
    // cycle where the SRAM word on data_sram_rdata belongs to r; if the stage
    // then holds, that word is parked in rdata_h so a later change of the
    // SRAM output cannot corrupt the pending load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r       <= '0;
            first   <= 1'b0;
            hv      <= 1'b0;
            rdata_h <= '0;
        end else if (bus.flush) begin
            r     <= '0;
            first <= 1'b1;
            hv    <= 1'b0;
        end else if (stall_mem && !stall_wb) begin
            r     <= '0;
            first <= 1'b1;
            hv    <= 1'b0;
        end else if (!stall_mem) begin
            r     <= bus.ex_to_mem_bus;
            first <= 1'b1;
            hv    <= 1'b0;
        end else begin
            first <= 1'b0;
            if (first) begin
                rdata_h <= bus.data_sram_rdata;
                hv      <= 1'b1;
            end
        end
    end

    logic [31:0] pc;
    logic        mem_ren;
    logic [2:0]  load_op;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign {pc, mem_ren, load_op, rf_we, rf_waddr, ex_result} = r;

    logic [31:0] rd;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;
    logic [31:0] rf_wdata;

    assign rd = hv ? rdata_h : bus.data_sram_rdata;

    always_comb begin
        sel_byte = rd[7:0];
        case (ex_result[1:0])
            2'd0:    sel_byte = rd[7:0];
            2'd1:    sel_byte = rd[15:8];
            2'd2:    sel_byte = rd[23:16];
            default: sel_byte = rd[31:24];
        endcase
        sel_half = ex_result[1] ? rd[31:16] : rd[15:0];

        load_val = rd;
        case (load_op)
            3'b001:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b010:  load_val = {24'b0, sel_byte};
            3'b011:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_val = {16'b0, sel_half};
            default: load_val = rd;
        endcase

        rf_wdata = mem_ren ? load_val : ex_result;
    end

    assign bus.mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};

`ifdef MEM_FWD_EN
    assign bus.mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};
`else
    assign bus.mem_to_id_bus = 38'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a behavioural reference model

module tb_mem_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_if ifc ();

    mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the instruction currently sitting in MEM, whether this
    // is its first cycle there, and the SRAM word it saw in that first cycle.
    logic [73:0] m_cur;
    bit          m_fresh;
    logic [31:0] m_word;

    task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [73:0] mk(input logic [31:0] pc, input logic ren,
                                       input logic [2:0] op, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {pc, ren, op, we, wa, res};
    endfunction

    function automatic logic [31:0] ld_val(input logic [2:0] op, input logic [31:0] w, input int off);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 128) ? b - 256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata();
        if (m_cur[41]) return ld_val(m_cur[40:38], m_word, int'(m_cur[1:0]));
        return m_cur[31:0];
    endfunction

    function automatic logic [73:0] m_wb();
        return {4'b0, m_cur[73:42], m_cur[37], m_cur[36:32], m_wdata()};
    endfunction

    function automatic logic [73:0] m_id();
`ifdef MEM_FWD_EN
        return {36'b0, m_cur[37], m_cur[36:32], m_wdata()};
`else
        return 74'b0;
`endif
    endfunction

    // Apply one cycle's inputs, then compare at the falling edge.
    task automatic drive(input logic [5:0] st, input logic fl, input logic [73:0] ex, input logic [31:0] rd);
        ifc.stall           = st;
        ifc.flush           = fl;
        ifc.ex_to_mem_bus   = ex;
        ifc.data_sram_rdata = rd;
        @(negedge clk);
        if (m_fresh) m_word = rd;
        chk("wb_bus", {4'b0, ifc.mem_to_wb_bus}, m_wb());
        chk("id_bus", {36'b0, ifc.mem_to_id_bus}, m_id());
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_cur   = '0;
            m_fresh = 1'b0;
        end else if (ifc.flush) begin
            m_cur   = '0;
            m_fresh = 1'b1;
        end else if (ifc.stall[3] && !ifc.stall[4]) begin
            m_cur   = '0;
            m_fresh = 1'b1;
        end else if (!ifc.stall[3]) begin
            m_cur   = ifc.ex_to_mem_bus;
            m_fresh = 1'b1;
        end else begin
            m_fresh = 1'b0;
        end
        #1;
    endtask

    logic [2:0]  ops [4]  = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [1:0]  offs [4] = '{2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011};

    localparam logic [5:0] ST_HOLD   = 6'b011000;
    localparam logic [5:0] ST_BUBBLE = 6'b001000;

    initial begin
        rst     = 1'b1;
        m_cur   = '0;
        m_fresh = 1'b0;
        m_word  = '0;
        ifc.stall = '0; ifc.flush = 1'b0; ifc.ex_to_mem_bus = '0; ifc.data_sram_rdata = '0;

        // Reset state
        drive(6'b0, 1'b0, mk(32'h1234, 1'b0, 3'd0, 1'b1, 5'd3, 32'h55), 32'h0);
        tick();
        chk("reset_wb", {4'b0, ifc.mem_to_wb_bus}, 74'b0);
        chk("reset_hv", {73'b0, dut.hv}, 74'b0);
        rst = 1'b0;

        // lw basic
        drive(6'b0, 1'b0, mk(32'hBFC00010, 1'b1, 3'd0, 1'b1, 5'd5, 32'h100), 32'h0);
        tick();
        drive(6'b0, 1'b0, 74'b0, 32'h8899AABB);
        chk("lw_basic", {4'b0, ifc.mem_to_wb_bus}, {4'b0, 32'hBFC00010, 1'b1, 5'd5, 32'h8899AABB});
        tick();

        // Byte/half extraction table
        for (int i = 0; i < 4; i++) begin
            drive(6'b0, 1'b0, mk(32'h40 + i, 1'b1, ops[i], 1'b1, 5'd9, {30'h40, offs[i]}), 32'h0);
            tick();
            drive(6'b0, 1'b0, 74'b0, 32'h80112233);
            chk($sformatf("ext_op%0d", ops[i]), {42'b0, ifc.mem_to_wb_bus[31:0]}, {42'b0, exps[i]});
            tick();
        end

        // lw held by MEM+WB stall while SRAM output changes
        drive(6'b0, 1'b0, mk(32'h200, 1'b1, 3'd0, 1'b1, 5'd7, 32'h8), 32'h0);
        tick();
        drive(ST_HOLD, 1'b0, 74'b0, 32'h12345678);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(i < 2 ? ST_HOLD : 6'b0, 1'b0, 74'b0, 32'hDEADBEEF);
            chk($sformatf("hold_%0d", i), {42'b0, ifc.mem_to_wb_bus[31:0]}, {42'b0, 32'h12345678});
            tick();
        end

        // Bubble: MEM stalled, WB not
        drive(6'b0, 1'b0, mk(32'h300, 1'b0, 3'd0, 1'b1, 5'd2, 32'h77), 32'h0);
        tick();
        drive(ST_BUBBLE, 1'b0, mk(32'h304, 1'b0, 3'd0, 1'b1, 5'd2, 32'h78), 32'h0);
        tick();
        drive(6'b0, 1'b0, 74'b0, 32'h0);
        chk("bubble_we", {73'b0, ifc.mem_to_wb_bus[37]}, 74'b0);
        chk("bubble_pc", {42'b0, ifc.mem_to_wb_bus[69:38]}, 74'b0);
        tick();

        // Flush together with stall
        drive(6'b0, 1'b0, mk(32'h400, 1'b0, 3'd0, 1'b1, 5'd4, 32'h99), 32'h0);
        tick();
        drive(ST_HOLD, 1'b1, mk(32'h404, 1'b0, 3'd0, 1'b1, 5'd4, 32'h9A), 32'h0);
        tick();
        drive(6'b0, 1'b0, 74'b0, 32'h0);
        chk("flush_stall", {4'b0, ifc.mem_to_wb_bus}, 74'b0);
        tick();

        // Non-load result and ID forward
        drive(6'b0, 1'b0, mk(32'h500, 1'b0, 3'd0, 1'b1, 5'd11, 32'h42), 32'h0);
        tick();
        drive(6'b0, 1'b0, 74'b0, 32'hCAFEF00D);
        chk("alu_wdata", {42'b0, ifc.mem_to_wb_bus[31:0]}, {42'b0, 32'h42});
`ifdef MEM_FWD_EN
        chk("alu_fwd", {36'b0, ifc.mem_to_id_bus}, {36'b0, 1'b1, 5'd11, 32'h42});
`else
        chk("alu_fwd", {36'b0, ifc.mem_to_id_bus}, 74'b0);
`endif
        tick();

        // Asynchronous reset mid-stall with a captured word
        drive(6'b0, 1'b0, mk(32'h600, 1'b1, 3'd0, 1'b1, 5'd6, 32'h4), 32'h0);
        tick();
        drive(ST_HOLD, 1'b0, 74'b0, 32'hA5A5A5A5);
        tick();
        chk("hv_captured", {73'b0, dut.hv}, {73'b0, 1'b1});
        #1 rst = 1'b1;
        #1;
        chk("async_rst_wb", {4'b0, ifc.mem_to_wb_bus}, 74'b0);
        chk("async_rst_hv", {73'b0, dut.hv}, 74'b0);
        m_cur   = '0;
        m_fresh = 1'b0;
        #1 rst = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic [5:0]  st;
            logic        fl;
            logic [73:0] ex;
            case ($urandom_range(0, 3))
                0, 1:    st = 6'b0;
                2:       st = ($urandom_range(0, 1) != 0) ? ST_HOLD : ST_BUBBLE;
                default: st = 6'($urandom);
            endcase
            fl = ($urandom_range(0, 15) == 0);
            ex = mk($urandom, 1'($urandom), 3'($urandom), 1'($urandom), 5'($urandom), $urandom);
            drive(st, fl, ex, $urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
